// File: rtl/lib_arbiter_pkg.sv
// Shared arbiter constants and scheduler types.
// Level-0 group geometry and the group scheduler state encoding.
package lib_arbiter_pkg;

  localparam int CONST0          = 4;
  localparam int Lvl0_GROUP_SIZE = 4;
  localparam int Lvl0_ADD        = 2;
  localparam int GRP_IDX_W       = $clog2(CONST0 * CONST0);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    PAUSE
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first request strictly after last,
// searching modulo N with wrap-around.
module rr_pick
  import lib_arbiter_pkg::*;
#(
  parameter int N  = CONST0 * CONST0,
  parameter int IW = GRP_IDX_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from farthest to nearest so the nearest request wins.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = N; i >= 1; i--) begin
      if (req_i[(int'(last_i) + i) % N]) begin
        idx_o = IW'((int'(last_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/l0_group_scheduler.sv
// Round-robin level-0 group scheduler with grant sequencing,
// idle timeout, address merge and a 2-entry FWFT event FIFO.
module l0_group_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int N_GRP    = CONST0,
  parameter int GRP_SIZE = Lvl0_GROUP_SIZE,
  parameter int ADD_W    = Lvl0_ADD,
  parameter int TIMEOUT  = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [N_GRP-1:0][N_GRP-1:0]         req_i,
  input  logic                                active_i,
  input  logic [ADD_W-1:0]                    x_add_i,
  input  logic [ADD_W-1:0]                    y_add_i,
  input  logic                                grp_release_i,
  output logic [N_GRP-1:0][N_GRP-1:0]         gnt_o,
  output logic                                event_valid_o,
  input  logic                                event_ready_i,
  output logic [ADD_W+$clog2(N_GRP)-1:0]      event_x_o,
  output logic [ADD_W+$clog2(N_GRP)-1:0]      event_y_o,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int NG2 = N_GRP * N_GRP;
  localparam int IW  = $clog2(NG2);
  localparam int RW  = $clog2(N_GRP);
  localparam int AW  = ADD_W + RW;
  localparam int CW  = $clog2(TIMEOUT);

  sched_state_t   state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [RW-1:0]  row_q, row_d;
  logic [RW-1:0]  col_q, col_d;
  logic [NG2-1:0] sel_q, sel_d;
  logic [NG2-1:0] gnt_q, gnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tmo_q, tmo_d;
  logic [1:0]     fcnt_q, fcnt_d;
  logic [AW-1:0]  ex0_q, ex0_d, ex1_q, ex1_d;
  logic [AW-1:0]  ey0_q, ey0_d, ey1_q, ey1_d;

  logic [NG2-1:0] req_flat;
  logic [IW-1:0]  win_idx;
  logic           any_req;
  logic           push, pop, tmo_hit;
  logic [1:0]     wslot;
  logic [AW-1:0]  new_x, new_y;

  assign req_flat = req_i;

  rr_pick #(
    .N  (NG2),
    .IW (IW)
  ) u_pick (
    .req_i  (req_flat),
    .last_i (last_q),
    .idx_o  (win_idx),
    .any_o  (any_req)
  );

  assign push    = (state_q == GRANT) && active_i;
  assign pop     = (fcnt_q != 2'd0) && event_ready_i;
  assign tmo_hit = !active_i && (cnt_q == CW'(TIMEOUT - 1));
  assign new_x   = AW'(row_q) * AW'(GRP_SIZE) + AW'(x_add_i);
  assign new_y   = AW'(col_q) * AW'(GRP_SIZE) + AW'(y_add_i);

  // FIFO: head in slot 0, pop shifts, push lands after survivors.
  always_comb begin
    ex0_d  = ex0_q;
    ex1_d  = ex1_q;
    ey0_d  = ey0_q;
    ey1_d  = ey1_q;
    fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
    wslot  = fcnt_q - {1'b0, pop};
    if (pop) begin
      ex0_d = ex1_q;
      ey0_d = ey1_q;
    end
    if (push) begin
      if (wslot == 2'd0) begin
        ex0_d = new_x;
        ey0_d = new_y;
      end else begin
        ex1_d = new_x;
        ey1_d = new_y;
      end
    end
  end

  // Grant sequencing: pick, hold until release/timeout, pause when full.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    row_d   = row_q;
    col_d   = col_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (any_req && fcnt_d != 2'd2) begin
          state_d = GRANT;
          last_d  = win_idx;
          row_d   = RW'(int'(win_idx) / N_GRP);
          col_d   = RW'(int'(win_idx) % N_GRP);
          sel_d   = NG2'(1) << win_idx;
          gnt_d   = NG2'(1) << win_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        cnt_d = active_i ? '0 : cnt_q + CW'(1);
        if (grp_release_i || tmo_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          tmo_d   = tmo_hit && !grp_release_i;
        end else if (fcnt_d == 2'd2) begin
          state_d = PAUSE;
          gnt_d   = '0;
        end
      end
      PAUSE: begin
        gnt_d = '0;
        if (fcnt_d != 2'd2) begin
          state_d = GRANT;
          gnt_d   = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State, pointer and FIFO registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      last_q  <= IW'(NG2 - 1);
      row_q   <= '0;
      col_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      fcnt_q  <= '0;
      ex0_q   <= '0;
      ex1_q   <= '0;
      ey0_q   <= '0;
      ey1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      fcnt_q  <= fcnt_d;
      ex0_q   <= ex0_d;
      ex1_q   <= ex1_d;
      ey0_q   <= ey0_d;
      ey1_q   <= ey1_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign event_valid_o = (fcnt_q != 2'd0);
  assign event_x_o     = ex0_q;
  assign event_y_o     = ey0_q;
  assign busy_o        = (state_q != IDLE);
  assign timeout_o     = tmo_q;

endmodule

// File: doc/l0_group_scheduler.md
# l0_group_scheduler

Round-robin scheduler for the level-0 pixel-group array. It consumes the per-group requests, drives the one-hot group enable matrix, and sequences each grant until the group signals release or times out. It merges the group-local row/column address with the group coordinate into an absolute pixel address, and delivers events through a 2-entry valid/ready output FIFO. It sits between the level-0 group array and the event readout path, replacing a higher hierarchy level when the design is two levels deep.

## Interface
Parameters:
- N_GRP, default CONST0 (4): groups per side; the array is N_GRP×N_GRP.
- GRP_SIZE, default Lvl0_GROUP_SIZE (4): pixels per group side, power of two.
- ADD_W, default Lvl0_ADD (2): group-local address width, equal to log2(GRP_SIZE).
- TIMEOUT, default 64: idle cycles allowed in a grant before forced release, ≥2.

Ports:
- clk_i, in, 1: clock. Single clock domain.
- reset_i, in, 1: synchronous, active-high reset.
- req_i, in, [N_GRP-1:0][N_GRP-1:0]: per-group request, indexed [row][col].
- active_i, in, 1: the enabled group is presenting a pixel this cycle.
- x_add_i, in, ADD_W: group-local row address, valid when active_i is high.
- y_add_i, in, ADD_W: group-local column address, valid when active_i is high.
- grp_release_i, in, 1: the enabled group has finished its arbitration pass.
- gnt_o, out, [N_GRP-1:0][N_GRP-1:0]: one-hot or zero group enable, registered.
- event_valid_o, out, 1: FIFO head is valid.
- event_ready_i, in, 1: the consumer accepts the FIFO head.
- event_x_o, out, ADD_W+log2(N_GRP): absolute row address of the FIFO head.
- event_y_o, out, ADD_W+log2(N_GRP): absolute column address of the FIFO head.
- busy_o, out, 1: the state machine is not in IDLE.
- timeout_o, out, 1: one-cycle pulse on a forced release.

## Operation
- **Flat index:** idx = row*N_GRP + col.
- **Round-robin pointer `last`:**
  - Reset value is N_GRP²-1, so group 0 wins first.
  - The winner is the first requesting idx after `last`, searching modulo N_GRP², with wrap-around.
  - `last` updates to the winner's idx at grant time.
- **State machine states:** IDLE, GRANT, PAUSE.
- **IDLE:**
  - gnt_o = 0.
  - If any req_i bit is set: latch the winner's row/col, register its gnt_o bit, go to GRANT.
  - Otherwise remain in IDLE.
- **GRANT:**
  - gnt_o holds the winner's bit.
  - active_i pushes {row·GRP_SIZE + x_add_i, col·GRP_SIZE + y_add_i} into the FIFO.
  - If grp_release_i is high, or the idle counter reaches TIMEOUT-1: go to IDLE with gnt_o = 0. On the timeout path only, pulse timeout_o.
  - Else if the post-update FIFO count is 2: go to PAUSE with gnt_o = 0.
- **PAUSE:**
  - gnt_o = 0. A disabled group holds its internal state and does not assert active_i.
  - When the post-update count is <2, return to GRANT and restore the latched bit.
  - The idle counter is frozen in PAUSE.
- **Idle counter:**
  - Clears on entry to GRANT and on any active_i.
  - Increments on each GRANT cycle without active_i.
- **FIFO:**
  - Depth 2, first-word-fall-through.
  - A push and a pop in the same cycle with count 2 is legal; the count stays 2.
  - Push while full with no pop is illegal. The bench asserts it never occurs.
- **Simultaneous events:**
  - active_i and grp_release_i in the same cycle: the event is pushed, then the release is taken.
  - Release while the FIFO is full: go to IDLE. A new grant is issued only when the FIFO count after update is <2.
  - req_i changing during GRANT is ignored until the next IDLE.

## Timing
- **Reset values (all outputs):** gnt_o = 0, event_valid_o = 0, event_x_o = 0, event_y_o = 0, busy_o = 0, timeout_o = 0. FIFO is empty. State is IDLE.
- **Grant latency:** req_i seen in IDLE at cycle t → gnt_o high at t+1.
- **Event latency:** active_i at t → event_valid_o at t+1 when the FIFO was empty.
- **Release turnaround:**
  - grp_release_i at t → gnt_o = 0 at t+1.
  - Next grant at t+2 at the earliest, giving a 1-cycle enable gap.
- **Pause:** FIFO full at end of t → gnt_o = 0 at t+1. Resume 1 cycle after a pop.
- **Reset mid-operation:** all state returns to reset values on the next edge. FIFO contents are discarded.

## Structure
- **Shared package lib_arbiter_pkg:**
  - Add typedef sched_state_t {IDLE, GRANT, PAUSE}.
  - Add constant GRP_IDX_W = $clog2(N_GRP²).
  - Reuse CONST0, Lvl0_GROUP_SIZE and Lvl0_ADD.
- **Sub-module rr_pick:**
  - Combinational rotate-priority-encoder over N_GRP² request bits.
  - Inputs: the request vector and `last`. Outputs: winner idx and any_req.
- The FIFO, state machine and counter are inline in the top module.

## Test plan
- **Single request:** req_i[2][1] held, event_ready_i = 1, one active_i with x = 3, y = 0, then grp_release_i → gnt_o[2][1] at t+1; event (11, 4) valid at the next cycle; gnt_o = 0 after the release.
- **Round-robin fairness:** all 16 requests held, each grant released after 1 event → grants visit idx 0, 1, …, 15, 0 in order.
- **Back-pressure:** event_ready_i = 0, active_i every cycle → gnt_o drops after 2 pushes and the FIFO holds 2 entries. Raising ready for 1 cycle resumes gnt_o 1 cycle later; no events are lost or duplicated.
- **Timeout:** grant to group 5, no active_i, no release → timeout_o pulses at cycle TIMEOUT after the grant; gnt_o = 0 next cycle; the next requester is granted.
- **Simultaneous active and release:** active_i and grp_release_i in the same cycle → event emitted, gnt_o = 0 next cycle, `last` advanced.
- **Reset mid-grant:** reset_i asserted while in PAUSE with the FIFO full → all outputs are zero after the edge; the first grant after reset goes to the lowest requesting idx.
